// File: rtl/servo_capture_pkg.sv
// servo_capture_pkg: shared types and helpers for the servo pulse capture block.
package servo_capture_pkg;
    localparam int US_W = 16;

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    typedef struct packed {
        logic [US_W-1:0] width;
        logic [US_W-1:0] period;
        logic            out_of_range;
        logic            overrun;
    } record_t;

    function automatic int div_of(input int clk_hz);
        return clk_hz / 1000000;
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser with level, rise/fall pulses and a settled flag.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk50,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall,
    output logic settled
);
    logic [STAGES-1:0] sync;
    logic [STAGES-1:0] fill;
    logic              prev;

    // fill tracks when the last stage holds a real sample rather than its reset value
    always_ff @(posedge clk50 or posedge rst)
        if (rst) begin
            sync <= '0;
            fill <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            fill <= {fill[STAGES-2:0], 1'b1};
            prev <= sync[STAGES-1];
        end

    assign level   = sync[STAGES-1];
    assign rise    = level & ~prev;
    assign fall    = ~level & prev;
    assign settled = fill[STAGES-1];
endmodule

// File: rtl/servo_pulse_capture.sv
// servo_pulse_capture: measures RC-servo pulse width and rise-to-rise period in whole microseconds.
module servo_pulse_capture
    import servo_capture_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_PULSE_US = 500,
    parameter int MAX_PULSE_US = 2500,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            ServoIn,
    input  logic            Ready,
    output logic            Valid,
    output logic [US_W-1:0] PulseWidthUs,
    output logic [US_W-1:0] PeriodUs,
    output logic            OutOfRange,
    output logic            Overrun,
    output logic            Timeout
);
    localparam int DIV = div_of(CLK_HZ);
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;

    logic            level, rise, fall, settled;
    logic [PW-1:0]   pre;
    logic [US_W-1:0] us, us_inc, width, period;
    logic            tick, timed_out, oor, emit;
    state_t          state;
    record_t         rec;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
        .clk50  (Clock),
        .rst    (Reset),
        .d      (ServoIn),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .settled(settled)
    );

    // us_inc includes this cycle's tick so a latched value is floor(cycles/DIV)
    assign tick      = pre == PW'(DIV - 1);
    assign us_inc    = (tick && us != '1) ? us + 1'b1 : us;
    assign timed_out = us >= US_W'(TIMEOUT_US);
    assign oor       = width < US_W'(MIN_PULSE_US) || width > US_W'(MAX_PULSE_US);

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            pre <= '0;
            us  <= '0;
        end else if (rise) begin
            pre <= '0;
            us  <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            us  <= us_inc;
        end

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state   <= IDLE;
            width   <= '0;
            period  <= '0;
            emit    <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            emit <= 1'b0;
            case (state)
                IDLE:      if (settled && !level) state <= WAIT_RISE;
                WAIT_RISE: if (rise) state <= HIGH;
                           else if (timed_out) Timeout <= 1'b1;
                HIGH:      if (fall) begin
                               width <= us_inc;
                               state <= LOW;
                           end else if (timed_out) begin
                               Timeout <= 1'b1;
                               state   <= IDLE;
                           end
                LOW:       if (rise) begin
                               period  <= us_inc;
                               emit    <= 1'b1;
                               Timeout <= 1'b0;
                               state   <= HIGH;
                           end else if (timed_out) begin
                               Timeout <= 1'b1;
                               state   <= WAIT_RISE;
                           end
            endcase
        end

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            Valid <= 1'b0;
            rec   <= '0;
        end else if (emit) begin
            Valid <= 1'b1;
            rec   <= '{width: width, period: period, out_of_range: oor, overrun: Valid && !Ready};
        end else if (Ready) begin
            Valid <= 1'b0;
        end

    assign PulseWidthUs = rec.width;
    assign PeriodUs     = rec.period;
    assign OutOfRange   = rec.out_of_range;
    assign Overrun      = rec.overrun;
endmodule
